// File: rtl/cajero_pkg.sv
// ============================================================================
// Module : cajero_pkg
// Brief  : Shared types and constants of the cashier transaction engine.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cajero_pkg;

    localparam int ANCHO_MONTO_DEF   = 32;
    localparam int ANCHO_BALANCE_DEF = 64;

    localparam logic TIPO_DEPOSITO = 1'b0;
    localparam logic TIPO_RETIRO   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        ESPERA = 2'd2
    } estado_t;

endpackage : cajero_pkg

`default_nettype wire

// File: rtl/calc_saldo.sv
// ============================================================================
// Module : calc_saldo
// Brief  : Combinational balance update and withdrawal admission check.
//          Optional single-withdrawal cap enabled by macro LIMITE_RETIRO_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_saldo
    import cajero_pkg::*;
#(
    parameter int          ANCHO_MONTO   = ANCHO_MONTO_DEF,
    parameter int          ANCHO_BALANCE = ANCHO_BALANCE_DEF,
    parameter int unsigned LIMITE_RETIRO = 32'd500000
) (
    input  logic [ANCHO_BALANCE-1:0] saldo,
    input  logic [ANCHO_MONTO-1:0]   monto,
    input  logic                     tipo,
    output logic [ANCHO_BALANCE-1:0] nuevo_saldo,
    output logic                     permitido
);

`ifdef LIMITE_RETIRO_EN
    localparam logic LIMITE_ACTIVO = 1'b1;
`else
    localparam logic LIMITE_ACTIVO = 1'b0;
`endif

    logic [ANCHO_BALANCE-1:0] monto_ext;
    logic                     fondos_ok;
    logic                     limite_ok;

    assign monto_ext = ANCHO_BALANCE'(monto);
    assign fondos_ok = (monto_ext <= saldo);
    // With the cap disabled this folds to constant 1.
    assign limite_ok = !LIMITE_ACTIVO || (monto_ext <= ANCHO_BALANCE'(LIMITE_RETIRO));

    always_comb begin
        nuevo_saldo = saldo + monto_ext;
        permitido   = 1'b1;
        if (tipo == TIPO_RETIRO) begin
            nuevo_saldo = saldo - monto_ext;
            permitido   = fondos_ok && limite_ok;
        end
    end

endmodule : calc_saldo

`default_nettype wire

// File: rtl/transaccion_ctrl.sv
// ============================================================================
// Module : transaccion_ctrl
// Brief  : Cashier transaction FSM: capture request, evaluate, wait card out.
//          Optional withdrawal cap via macro LIMITE_RETIRO_EN (in calc_saldo).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module transaccion_ctrl
    import cajero_pkg::*;
#(
    parameter int          ANCHO_MONTO   = ANCHO_MONTO_DEF,
    parameter int          ANCHO_BALANCE = ANCHO_BALANCE_DEF,
    parameter int unsigned LIMITE_RETIRO = 32'd500000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tarjeta_recibida,
    input  logic                     tipo_trans,
    input  logic [ANCHO_MONTO-1:0]   monto,
    input  logic [ANCHO_BALANCE-1:0] balance_inicial,
    output logic [ANCHO_BALANCE-1:0] balance_actualizado,
    output logic                     balance_stb,
    output logic                     entregar_dinero,
    output logic                     fondos_insuficientes
);

    estado_t                  estado_q;
    logic                     tipo_q;
    logic [ANCHO_MONTO-1:0]   monto_q;
    logic [ANCHO_BALANCE-1:0] saldo_q;
    logic [ANCHO_BALANCE-1:0] balance_q;
    logic                     stb_q;
    logic                     entregar_q;
    logic                     fondos_q;

    logic [ANCHO_BALANCE-1:0] saldo_d;
    logic                     permitido_d;

    calc_saldo #(
        .ANCHO_MONTO   (ANCHO_MONTO),
        .ANCHO_BALANCE (ANCHO_BALANCE),
        .LIMITE_RETIRO (LIMITE_RETIRO)
    ) u_calc_saldo (
        .saldo       (saldo_q),
        .monto       (monto_q),
        .tipo        (tipo_q),
        .nuevo_saldo (saldo_d),
        .permitido   (permitido_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q   <= IDLE;
            tipo_q     <= TIPO_DEPOSITO;
            monto_q    <= '0;
            saldo_q    <= '0;
            balance_q  <= '0;
            stb_q      <= 1'b0;
            entregar_q <= 1'b0;
            fondos_q   <= 1'b0;
        end else begin
            case (estado_q)
                IDLE: begin
                    stb_q      <= 1'b0;
                    entregar_q <= 1'b0;
                    if (tarjeta_recibida) begin
                        tipo_q   <= tipo_trans;
                        monto_q  <= monto;
                        saldo_q  <= balance_inicial;
                        estado_q <= EVAL;
                    end
                end
                EVAL: begin
                    if (permitido_d) begin
                        balance_q  <= saldo_d;
                        stb_q      <= 1'b1;
                        entregar_q <= (tipo_q == TIPO_RETIRO);
                    end else begin
                        fondos_q <= 1'b1;
                    end
                    estado_q <= ESPERA;
                end
                ESPERA: begin
                    stb_q      <= 1'b0;
                    entregar_q <= 1'b0;
                    // One transaction per session: stay until the card leaves.
                    if (!tarjeta_recibida) begin
                        fondos_q <= 1'b0;
                        estado_q <= IDLE;
                    end
                end
                default: begin
                    stb_q      <= 1'b0;
                    entregar_q <= 1'b0;
                    fondos_q   <= 1'b0;
                    estado_q   <= IDLE;
                end
            endcase
        end
    end

    assign balance_actualizado  = balance_q;
    assign balance_stb          = stb_q;
    assign entregar_dinero      = entregar_q;
    assign fondos_insuficientes = fondos_q;

endmodule : transaccion_ctrl

`default_nettype wire

// File: tb/tb_transaccion_ctrl.sv
// ============================================================================
// Module : tb_transaccion_ctrl
// Brief  : Directed self-checking bench for transaccion_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_transaccion_ctrl;

    logic        clk;
    logic        reset;
    logic        tarjeta_recibida;
    logic        tipo_trans;
    logic [31:0] monto;
    logic [63:0] balance_inicial;
    logic [63:0] balance_actualizado;
    logic        balance_stb;
    logic        entregar_dinero;
    logic        fondos_insuficientes;

    int checks = 0;
    int errors = 0;

    transaccion_ctrl #(
        .ANCHO_MONTO   (32),
        .ANCHO_BALANCE (64),
        .LIMITE_RETIRO (32'd500000)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .tarjeta_recibida     (tarjeta_recibida),
        .tipo_trans           (tipo_trans),
        .monto                (monto),
        .balance_inicial      (balance_inicial),
        .balance_actualizado  (balance_actualizado),
        .balance_stb          (balance_stb),
        .entregar_dinero      (entregar_dinero),
        .fondos_insuficientes (fondos_insuficientes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts at a falling edge with the FSM idle; ends idle with the card out.
    task automatic sesion(input string nm, input logic tipo, input logic [31:0] m,
                          input logic [63:0] b, input logic [63:0] exp_bal,
                          input logic exp_stb, input logic exp_ent, input logic exp_fondos);
        tipo_trans       = tipo;
        monto            = m;
        balance_inicial  = b;
        tarjeta_recibida = 1'b1;
        cycle();
        check({nm, ":eval_stb"}, 64'(balance_stb), 64'd0);
        check({nm, ":eval_ent"}, 64'(entregar_dinero), 64'd0);
        cycle();
        check({nm, ":stb"}, 64'(balance_stb), 64'(exp_stb));
        check({nm, ":ent"}, 64'(entregar_dinero), 64'(exp_ent));
        check({nm, ":fondos"}, 64'(fondos_insuficientes), 64'(exp_fondos));
        check({nm, ":bal"}, balance_actualizado, exp_bal);
        tipo_trans      = ~tipo;
        monto           = m + 32'd7;
        balance_inicial = b ^ 64'h55;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check({nm, ":hold_stb"}, 64'(balance_stb), 64'd0);
            check({nm, ":hold_ent"}, 64'(entregar_dinero), 64'd0);
            check({nm, ":hold_fondos"}, 64'(fondos_insuficientes), 64'(exp_fondos));
            check({nm, ":hold_bal"}, balance_actualizado, exp_bal);
        end
        tarjeta_recibida = 1'b0;
        cycle();
        check({nm, ":out_fondos"}, 64'(fondos_insuficientes), 64'd0);
        check({nm, ":out_stb"}, 64'(balance_stb), 64'd0);
        check({nm, ":out_bal"}, balance_actualizado, exp_bal);
    endtask

    initial begin
        reset            = 1'b0;
        tarjeta_recibida = 1'b1;
        tipo_trans       = 1'b0;
        monto            = 32'd250;
        balance_inicial  = 64'd1000;

        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rst_stb", 64'(balance_stb), 64'd0);
            check("rst_ent", 64'(entregar_dinero), 64'd0);
            check("rst_fondos", 64'(fondos_insuficientes), 64'd0);
            check("rst_bal", balance_actualizado, 64'd0);
        end
        reset = 1'b1;

        sesion("deposito", 1'b0, 32'd250, 64'd1000, 64'd1250, 1'b1, 1'b0, 1'b0);
        sesion("retiro", 1'b1, 32'd300, 64'd1000, 64'd700, 1'b1, 1'b1, 1'b0);
        sesion("retiro_exacto", 1'b1, 32'd1000, 64'd1000, 64'd0, 1'b1, 1'b1, 1'b0);
        sesion("retiro_excede", 1'b1, 32'd1001, 64'd1000, 64'd0, 1'b0, 1'b0, 1'b1);
`ifdef LIMITE_RETIRO_EN
        sesion("retiro_limite", 1'b1, 32'd600000, 64'd1000000, 64'd0, 1'b0, 1'b0, 1'b1);
`else
        sesion("retiro_limite", 1'b1, 32'd600000, 64'd1000000, 64'd400000, 1'b1, 1'b1, 1'b0);
`endif
        sesion("deposito_wrap", 1'b0, 32'h200, 64'hFFFF_FFFF_FFFF_FF00, 64'h100, 1'b1, 1'b0, 1'b0);

        // Card removed while EVAL is running: rejection still flagged for one cycle.
        tipo_trans       = 1'b1;
        monto            = 32'd10;
        balance_inicial  = 64'd5;
        tarjeta_recibida = 1'b1;
        cycle();
        tarjeta_recibida = 1'b0;
        cycle();
        check("drop_fondos", 64'(fondos_insuficientes), 64'd1);
        check("drop_stb", 64'(balance_stb), 64'd0);
        check("drop_bal", balance_actualizado, 64'h100);
        cycle();
        check("drop_fondos_clr", 64'(fondos_insuficientes), 64'd0);

        tipo_trans       = 1'b0;
        monto            = 32'd5;
        balance_inicial  = 64'd10;
        tarjeta_recibida = 1'b1;
        cycle();
        tarjeta_recibida = 1'b0;
        cycle();
        check("dropdep_stb", 64'(balance_stb), 64'd1);
        check("dropdep_bal", balance_actualizado, 64'd15);
        cycle();
        check("dropdep_stb_clr", 64'(balance_stb), 64'd0);
        cycle();
        check("dropdep_idle_stb", 64'(balance_stb), 64'd0);

        // Reset during EVAL: outputs clear at once and no pulse follows.
        tipo_trans       = 1'b1;
        monto            = 32'd3;
        balance_inicial  = 64'd9;
        tarjeta_recibida = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        check("midrst_bal", balance_actualizado, 64'd0);
        check("midrst_stb", 64'(balance_stb), 64'd0);
        tarjeta_recibida = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("postrst_stb", 64'(balance_stb), 64'd0);
            check("postrst_ent", 64'(entregar_dinero), 64'd0);
            check("postrst_bal", balance_actualizado, 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_transaccion_ctrl

`default_nettype wire
